// File: rtl/div_nbit.sv
// rtl/div_nbit.sv - multi-cycle restoring radix-2 divider, signed or unsigned
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = two's-complement division, 0 = unsigned (sampled with start)
//   opdata1_i     dividend (sampled with start)
//   opdata2_i     divisor  (sampled with start)
//   start_i       division request, held high until ready_o is seen
//   annul_i       abort the division in progress
//   result_o      {remainder, quotient}, quotient in the low WIDTH bits
//   ready_o       result_o is valid
//   busy_o        block is not idle
//   div_zero_o    result came from a zero divisor (valid while ready_o=1)

module div_nbit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   dvd;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   partial;    // partial remainder
    logic               neg_quot;
    logic               neg_rem;

    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   quot_next;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Magnitudes; the most-negative value maps onto itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value and the difference both fit in WIDTH+1 bits and
    // the MSB of the difference is a clean borrow/sign indicator.
    always_comb begin
        shifted   = {partial, dvd[WIDTH-1]};
        diff      = shifted - {1'b0, divisor};
        q_bit     = ~diff[WIDTH];
        rem_next  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_next = {dvd[WIDTH-2:0], q_bit};
        quot_fix  = neg_quot ? -quot_next : quot_next;
        rem_fix   = neg_rem  ? -rem_next  : rem_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FREE;
            cnt        <= '0;
            dvd        <= '0;
            divisor    <= '0;
            partial    <= '0;
            neg_quot   <= 1'b0;
            neg_rem    <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            unique case (state)
                FREE: begin
                    if (start_i && !annul_i) begin
                        dvd      <= op1_abs;
                        divisor  <= op2_abs;
                        partial  <= '0;
                        cnt      <= '0;
                        neg_quot <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem  <= signed_div_i && opdata1_i[WIDTH-1];
                        busy_o   <= 1'b1;
                        state    <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end

                BYZERO: begin
                    if (annul_i) begin
                        busy_o <= 1'b0;
                        state  <= FREE;
                    end else begin
                        result_o   <= '0;
                        div_zero_o <= 1'b1;
                        ready_o    <= 1'b1;
                        state      <= END;
                    end
                end

                ON: begin
                    if (annul_i) begin
                        busy_o <= 1'b0;
                        state  <= FREE;
                    end else begin
                        dvd     <= quot_next;
                        partial <= rem_next;
                        cnt     <= cnt + CW'(1);
                        // Sign correction is folded into the last step so the
                        // result is already final when ready_o rises.
                        if (cnt == CW'(WIDTH - 1)) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                            state    <= END;
                        end
                    end
                end

                END: begin
                    // Stay here while the requester still holds start_i, so a
                    // held request cannot launch a second division.
                    if (!start_i) begin
                        result_o   <= '0;
                        ready_o    <= 1'b0;
                        div_zero_o <= 1'b0;
                        busy_o     <= 1'b0;
                        state      <= FREE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_nbit.sv
// tb/tb_div_nbit.sv - scoreboard testbench for div_nbit (WIDTH=32 and WIDTH=8)

module tb_div_nbit;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          edge_no;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        s32, st32, an32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32, busy32, dz32;

    logic        s8, st8, an8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, busy8, dz8;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    logic prev32 = 1'b0;
    logic prev8  = 1'b0;

    div_nbit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .signed_div_i(s32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32),
        .busy_o(busy32), .div_zero_o(dz32)
    );

    div_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8),
        .busy_o(busy8), .div_zero_o(dz8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expectation on each rising ready_o.
    always @(posedge clk) begin
        #1;
        if (rdy32 === 1'b1 && prev32 !== 1'b1) begin
            if (q32.size() == 0) begin
                chk("spurious_ready32", 64'd1, 64'd0);
            end else begin
                e32 = q32.pop_front();
                chk("result32", res32, e32.res);
                chk("div_zero32", {63'd0, dz32}, {63'd0, e32.dz});
                chk("latency32", 64'(cyc), 64'(e32.edge_no));
            end
        end
        if (rdy32 === 1'b0) chk("idle_outputs32", {res32[62:0], dz32}, 64'd0);
        prev32 = rdy32;
    end

    always @(posedge clk) begin
        #1;
        if (rdy8 === 1'b1 && prev8 !== 1'b1) begin
            if (q8.size() == 0) begin
                chk("spurious_ready8", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("result8", {48'd0, res8}, e8.res);
                chk("div_zero8", {63'd0, dz8}, {63'd0, e8.dz});
                chk("latency8", 64'(cyc), 64'(e8.edge_no));
            end
        end
        if (rdy8 === 1'b0) chk("idle_outputs8", {47'd0, res8, dz8}, 64'd0);
        prev8 = rdy8;
    end

    // Called at a negedge; the request is taken at the following edge.
    task automatic push32(input logic [31:0] q, input logic [31:0] r, input logic dz);
        exp_t e;
        e.res = {r, q};
        e.dz = dz;
        e.edge_no = cyc + 1 + (dz ? 1 : 32);
        q32.push_back(e);
    endtask

    task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input logic dz);
        s32 = s; a32 = a; b32 = b; st32 = 1'b1;
        push32(q, r, dz);
    endtask

    task automatic complete32();
        logic        got = 1'b0;
        logic [63:0] held;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a32 = ~a32; b32 = 32'h0; s32 = ~s32;
            end
            if (rdy32) begin
                got = 1'b1;
                break;
            end
        end
        chk("ready32_seen", {63'd0, got}, 64'd1);
        chk("busy_in_end32", {63'd0, busy32}, 64'd1);
        held = res32;
        an32 = 1'b1;
        @(negedge clk);
        chk("hold_in_end32", {rdy32, res32[62:0]}, {1'b1, held[62:0]});
        an32 = 1'b0;
        st32 = 1'b0;
        @(negedge clk);
        chk("clear_after_drop32", {62'd0, rdy32, busy32}, 64'd0);
    endtask

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r, input logic dz);
        exp_t e;
        logic got = 1'b0;
        s8 = s; a8 = a; b8 = b; st8 = 1'b1;
        e.res = {48'd0, r, q};
        e.dz = dz;
        e.edge_no = cyc + 1 + (dz ? 1 : 8);
        q8.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a8 = ~a8; b8 = 8'h0;
            end
            if (rdy8) begin
                got = 1'b1;
                break;
            end
        end
        chk("ready8_seen", {63'd0, got}, 64'd1);
        st8 = 1'b0;
        @(negedge clk);
        chk("clear_after_drop8", {62'd0, rdy8, busy8}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        s32 = 0; st32 = 0; an32 = 0; a32 = 0; b32 = 0;
        s8 = 0; st8 = 0; an8 = 0; a8 = 0; b8 = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs32", {res32[61:0], rdy32, busy32}, 64'd0);
        chk("reset_dz32", {63'd0, dz32}, 64'd0);

        // First request presented together with reset release.
        rst = 1'b0;
        issue32(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
        complete32();

        issue32(1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        complete32();
        issue32(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
        complete32();
        issue32(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        complete32();
        issue32(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0);
        complete32();
        issue32(1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0);
        complete32();
        issue32(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
        complete32();

        // Abort: 100/3 annulled at cycle 10, nothing may come out of it.
        s32 = 1'b0; a32 = 32'd100; b32 = 32'd3; st32 = 1'b1;
        repeat (10) @(negedge clk);
        an32 = 1'b1; st32 = 1'b0;
        @(negedge clk);
        chk("annul_to_free32", {62'd0, rdy32, busy32}, 64'd0);
        an32 = 1'b0;
        issue32(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        complete32();

        // Reset mid-division with start held through it.
        s32 = 1'b0; a32 = 32'd100; b32 = 32'd7; st32 = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_on32", {res32[61:0], rdy32, busy32}, 64'd0);
        rst = 1'b0;
        push32(32'd14, 32'd2, 1'b0);
        complete32();

        run8(1'b0, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0);
        run8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        run8(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
        run8(1'b0, 8'h05, 8'h00, 8'h00, 8'h00, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained32", 64'(q32.size()), 64'd0);
        chk("scoreboard_drained8", 64'(q8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
